// File: rtl/lfsr_pkg.sv
// Shared FSM encoding and maximal-length feedback masks for the LFSR random generator.
// Combinational constants only; no timing or flow-control behaviour.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lfsr_state_e;

    localparam int LFSR_CNT_W = 8;

    // Bit i set means state[i] feeds the XOR; polynomial taps n map to bit n-1.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_random_gen.sv
// Fibonacci LFSR with free-run mode and a request FSM producing a number after STEPS shifts.
// Latency: req sampled at edge k gives valid after edge k+STEPS; no backpressure, valid is a one-cycle pulse.
module lfsr_random_gen
    import lfsr_pkg::*;
#(
    parameter int              WIDTH      = 10,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter int              STEPS      = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             req,
    output logic [WIDTH-1:0] random_number,
    output logic             valid,
    output logic             busy,
    output logic             zero_seed
);

    lfsr_state_e            r_fsm;
    logic [LFSR_CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]       r_state;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_zero_seed;

    logic                   w_feedback;
    logic [WIDTH-1:0]       w_shifted;
    logic                   w_seed_zero;

    always_comb begin
        w_feedback  = ^(r_state & TAPS);
        w_shifted   = {r_state[WIDTH-2:0], w_feedback};
        w_seed_zero = (seed == '0);
    end

    // Each branch writes r_state at most once, so at most one shift happens per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_SEED;
            r_fsm       <= ST_IDLE;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_zero_seed <= 1'b0;
        end else if (load) begin
            r_state     <= w_seed_zero ? RESET_SEED : seed;
            r_zero_seed <= w_seed_zero;
            r_fsm       <= ST_IDLE;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (req) begin
                        r_fsm   <= ST_SHIFT;
                        r_count <= LFSR_CNT_W'(STEPS - 1);
                        r_busy  <= 1'b1;
                    end else if (en) begin
                        r_state <= w_shifted;
                    end
                end
                ST_SHIFT: begin
                    r_state <= w_shifted;
                    if (r_count == '0) begin
                        r_fsm   <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - LFSR_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_fsm  <= ST_IDLE;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_fsm  <= ST_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign random_number = r_state;
    assign valid         = r_valid;
    assign busy          = r_busy;
    assign zero_seed     = r_zero_seed;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Directed self-checking bench for lfsr_random_gen at default parameters, with a scoreboard of requested numbers.
module tb_lfsr_random_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [9:0] seed;
    logic       en;
    logic       req;
    logic [9:0] random_number;
    logic       valid;
    logic       busy;
    logic       zero_seed;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int cyc      = 0;

    logic [9:0] sb_q[$];
    logic [9:0] m;

    lfsr_random_gen dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .seed          (seed),
        .en            (en),
        .req           (req),
        .random_number (random_number),
        .valid         (valid),
        .busy          (busy),
        .zero_seed     (zero_seed)
    );

    always #5 clk = ~clk;

    // Reference polynomial x^10 + x^7 + 1 written directly from its taps.
    function automatic logic [9:0] nxt(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            n_valid++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_value", 32'(random_number), 32'(e));
            end else begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end
        end
    endtask

    initial begin
        int busy_cnt;
        int v0;
        int first_ret;
        int zero_hit;
        int dup;
        int mism;
        int last_pulse;
        int pulses;
        logic [9:0] e;
        logic seen [1024];

        rst = 1'b1; load = 1'b0; seed = '0; en = 1'b0; req = 1'b0;

        // Reset values while rst is held.
        #3;
        chk("rst_rn", 32'(random_number), 32'h001);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_zero_seed", 32'(zero_seed), 32'd0);
        tick(); tick();
        rst = 1'b0;
        m = 10'h001;

        // Idle with en=0: state frozen.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_rn", 32'(random_number), 32'h001);
            chk("idle_valid", 32'(valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single request from 001.
        e = m;
        for (int i = 0; i < 10; i++) e = nxt(e);
        sb_q.push_back(e);
        v0 = n_valid;
        req = 1'b1;
        tick();
        req = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        chk("req_no_shift", 32'(random_number), 32'(m));
        for (int i = 0; i < 10; i++) begin
            tick();
            m = nxt(m);
            chk("req_path", 32'(random_number), 32'(m));
            if (busy === 1'b1) busy_cnt++;
        end
        chk("req_result_const", 32'(random_number), 32'h009);
        chk("req_valid_pulse", 32'(valid), 32'd1);
        tick();
        if (busy === 1'b1) busy_cnt++;
        chk("done_rn_stable", 32'(random_number), 32'h009);
        chk("done_valid_drop", 32'(valid), 32'd0);
        tick();
        chk("req_busy_cycles", 32'(busy_cnt), 32'd11);
        chk("req_valid_count", 32'(n_valid - v0), 32'd1);
        chk("req_busy_clear", 32'(busy), 32'd0);

        // Zero seed substitution, then a nonzero seed clears the flag.
        load = 1'b1; seed = 10'h000;
        tick();
        load = 1'b0;
        chk("zseed_rn", 32'(random_number), 32'h001);
        chk("zseed_flag", 32'(zero_seed), 32'd1);
        tick();
        chk("zseed_sticky", 32'(zero_seed), 32'd1);
        load = 1'b1; seed = 10'h155;
        tick();
        load = 1'b0;
        chk("seed155_rn", 32'(random_number), 32'h155);
        chk("seed155_flag", 32'(zero_seed), 32'd0);

        // Full period in free-run mode from 001.
        load = 1'b1; seed = 10'h001;
        tick();
        load = 1'b0;
        m = 10'h001;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        first_ret = 0; zero_hit = 0; dup = 0; mism = 0;
        en = 1'b1;
        for (int c = 1; c <= 1023; c++) begin
            tick();
            m = nxt(m);
            if (random_number !== m) mism++;
            if (random_number === 10'h000) zero_hit++;
            if (random_number === 10'h001) begin
                if (first_ret == 0) first_ret = c;
            end else if (seen[random_number]) begin
                dup++;
            end else begin
                seen[random_number] = 1'b1;
            end
        end
        en = 1'b0;
        chk("period_first_return", 32'(first_ret), 32'd1023);
        chk("period_nonzero", 32'(zero_hit), 32'd0);
        chk("period_no_repeat", 32'(dup), 32'd0);
        chk("period_model_track", 32'(mism), 32'd0);

        // Load aborts a request in its 4th SHIFT cycle.
        v0 = n_valid;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick(); tick();
        load = 1'b1; seed = 10'h3FF;
        tick();
        load = 1'b0;
        chk("abort_rn", 32'(random_number), 32'h3FF);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("abort_rn_hold", 32'(random_number), 32'h3FF);
        chk("abort_no_pulse", 32'(n_valid - v0), 32'd0);

        // Asynchronous reset mid-request.
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rn", 32'(random_number), 32'h001);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("arst_rn_hold", 32'(random_number), 32'h001);
        chk("arst_no_pulse", 32'(n_valid - v0), 32'd0);
        m = 10'h001;

        // req held with en=1: one number every 12 cycles, 10 shifts apart.
        e = m;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 10; i++) e = nxt(e);
            sb_q.push_back(e);
        end
        req = 1'b1; en = 1'b1;
        last_pulse = -1; pulses = 0;
        for (int i = 0; i < 60; i++) begin
            v0 = n_valid;
            tick();
            if (n_valid != v0) begin
                if (last_pulse >= 0) chk("held_interval", 32'(cyc - last_pulse), 32'd12);
                last_pulse = cyc;
                pulses++;
            end
        end
        req = 1'b0; en = 1'b0;
        tick(); tick();
        chk("held_pulse_count", 32'(pulses), 32'd5);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
